chi_tx_scheduler: RTL and testbench
===================================

Name: chi_tx_scheduler

Overview:
- Schedules CHI flits from NUM_SRC internal sources (coherence FSM, snoop broadcaster, memory read path, data return) onto one CHI TX channel of the Home Node.
- Provides round-robin arbitration between the sources.
- Counts link-layer credits (L-credits) and only sends a flit when a credit is held.
- Drives FLITPEND one cycle ahead of FLITV.
- One instance is used per TX channel (REQ, RSP, DAT).

Parameters:
- NUM_SRC, 4, number of requesting sources (≥2).
- FLIT_W, 128, flit width in bits.
- MAX_CRD, 15, maximum L-credits the receiver may grant.
- CRD_W, 4, credit counter width; must satisfy MAX_CRD < 2^CRD_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- link_en  in  1  link active; when 0, no new grants are issued.
- src_valid  in  NUM_SRC  a source has a flit to send.
- src_flit  in  NUM_SRC*FLIT_W  packed flits; source i occupies bits [i*FLIT_W +: FLIT_W].
- src_grant  out  NUM_SRC  one-hot, one-cycle pulse; the flit is accepted in this cycle.
- TX_FLITPEND  out  1  flit pending (one cycle early warning).
- TX_FLITV  out  1  flit valid.
- TX_FLIT_128  out  FLIT_W  flit payload.
- TX_LCRDV  in  1  one credit returned per asserted cycle.
- crd_cnt  out  CRD_W  credits currently held.
- crd_ovf  out  1  sticky error flag: a credit arrived while already at MAX_CRD.

Behaviour:
- Reset values: src_grant=0, TX_FLITPEND=0, TX_FLITV=0, TX_FLIT_128=0, crd_cnt=0, crd_ovf=0, rr_ptr=0, state=IDLE.
- Reset mid-operation: any in-flight flit is dropped; FLITV is not asserted after reset release.
- Grant condition in cycle t: link_en=1 and crd_avail>0 and |src_valid.
  - crd_avail = crd_cnt + TX_LCRDV; a credit arriving in the same cycle can be used.
- Arbitration is round-robin. Start at rr_ptr and pick the first i with src_valid[i]=1, wrapping modulo NUM_SRC.
  - After a grant to source w, rr_ptr <= (w+1) mod NUM_SRC.
  - rr_ptr is unchanged when there is no grant.
- src_grant[w] is combinational in cycle t. The flit is latched into the pipe register at the end of cycle t.
- The source must hold its flit stable while src_valid=1 until it is granted.
- Timing of a flit granted at t:
  - TX_FLITPEND=1 in cycle t+1.
  - TX_FLITV=1 with TX_FLIT_128 in cycle t+2.
  - Latency is 2 cycles.
- Back-to-back: a grant is allowed every cycle. FLITPEND stays high across consecutive grants, and FLITV gives one flit per cycle at full throughput.
- TX_FLITPEND is 1 in cycle t+1 for each grant at t, and 0 otherwise.
- TX_FLIT_128 holds its last value when FLITV=0.
- Credit arithmetic, applied every cycle:
  - crd_cnt_next = crd_cnt + TX_LCRDV − grant.
  - A credit is consumed at grant time, not at FLITV, so the credit is reserved for the flit.
  - Simultaneous LCRDV and grant leaves crd_cnt unchanged.
  - With crd_cnt=0 and LCRDV=1 in the same cycle, a grant is allowed and crd_cnt stays 0.
  - If crd_cnt=MAX_CRD, LCRDV=1 and there is no grant: crd_cnt saturates at MAX_CRD and crd_ovf is set until rst.
- FSM (TX pipe state):
  - IDLE: FLITPEND=0. On grant → PEND.
  - PEND: FLITPEND was asserted this cycle. Next cycle FLITV=1. On a new grant → SEND_PEND, else → SEND.
  - SEND: FLITV=1. On grant → PEND, else → IDLE.
  - SEND_PEND: FLITV=1 with FLITPEND=1. On grant stay in SEND_PEND, else → SEND.
- Boundary cases:
  - Zero credits: no grant; sources wait; FLITPEND=0.
  - link_en falling: no new grants; up to 2 already-granted flits complete normally; credits are kept.
  - Single requester: granted every cycle while credits last.
  - All sources valid: each source is granted exactly once per NUM_SRC grants.

Decomposition:
- Shared package chi_pkg holds:
  - FLIT_W.
  - Channel credit maxima (REQ/RSP/DAT).
  - Node ID constants (RN1–RN4, RNX broadcast, SN).
  - HN tx/rx opcode constants, moved out of the coherence controller.
- One sub-module, rr_arbiter: parameterised NUM_SRC, inputs req/ptr, outputs one-hot grant.
- The credit counter and FSM stay in chi_tx_scheduler.

Test Plan:
- Reset then 3 TX_LCRDV pulses, src_valid=0001 held:
  - Grants at 3 consecutive cycles.
  - FLITPEND high for 3 cycles, FLITV high for 3 cycles, shifted by +1.
  - crd_cnt returns to 0; the fourth flit stalls.
- All 4 sources valid, 8 credits preloaded:
  - Grant order 0,1,2,3,0,1,2,3.
  - TX_FLIT_128 sequence matches the sources.
  - crd_cnt=0 after 8 grants.
- crd_cnt=0 with LCRDV=1 and src_valid=0100 in the same cycle:
  - Grant to src 2 that cycle.
  - crd_cnt stays 0.
  - FLITV occurs 2 cycles later.
- 16 LCRDV pulses with no traffic:
  - crd_cnt saturates at 15.
  - crd_ovf=1 and stays 1 until rst.
- link_en dropped the cycle after 2 back-to-back grants:
  - Both flits appear on FLITV.
  - No further grants while src_valid=1111.
  - Grants resume the cycle link_en returns high.
- rst asserted while state=SEND_PEND:
  - All outputs 0 immediately (asynchronous).
  - No FLITV after release.
  - crd_cnt=0.

Source files
------------

// File: rtl/chi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chi_pkg
// Description : Shared CHI constants for the Home Node: flit width, channel
//               credit limits, node IDs, HN opcodes and the TX pipe states.
// Revision    : 1.0 - initial release
// ============================================================================
package chi_pkg;

    localparam int CHI_FLIT_W  = 128;

    localparam int REQ_MAX_CRD = 15;
    localparam int RSP_MAX_CRD = 15;
    localparam int DAT_MAX_CRD = 15;

    localparam logic [6:0] NID_RN1 = 7'd1;
    localparam logic [6:0] NID_RN2 = 7'd2;
    localparam logic [6:0] NID_RN3 = 7'd3;
    localparam logic [6:0] NID_RN4 = 7'd4;
    localparam logic [6:0] NID_RNX = 7'h7F;
    localparam logic [6:0] NID_SN  = 7'd8;

    // Opcodes the HN emits
    localparam logic [5:0] HN_TX_SNP_SHARED      = 6'h01;
    localparam logic [5:0] HN_TX_SNP_UNIQUE      = 6'h07;
    localparam logic [5:0] HN_TX_SNP_CLEAN_INV   = 6'h09;
    localparam logic [5:0] HN_TX_READ_NO_SNP     = 6'h04;
    localparam logic [5:0] HN_TX_WRITE_NO_SNP_F  = 6'h1D;
    localparam logic [3:0] HN_TX_RSP_COMP        = 4'h4;
    localparam logic [3:0] HN_TX_RSP_COMP_DBID   = 4'h5;
    localparam logic [3:0] HN_TX_RSP_RETRY_ACK   = 4'h3;
    localparam logic [3:0] HN_TX_DAT_COMP_DATA   = 4'h4;

    // Opcodes the HN receives
    localparam logic [5:0] HN_RX_READ_SHARED     = 6'h01;
    localparam logic [5:0] HN_RX_READ_UNIQUE     = 6'h07;
    localparam logic [5:0] HN_RX_CLEAN_UNIQUE    = 6'h0B;
    localparam logic [5:0] HN_RX_WRITE_BACK_FULL = 6'h1B;
    localparam logic [3:0] HN_RX_RSP_SNP_RESP    = 4'h1;
    localparam logic [3:0] HN_RX_RSP_COMP_ACK    = 4'h2;
    localparam logic [3:0] HN_RX_DAT_CB_WR_DATA  = 4'h2;
    localparam logic [3:0] HN_RX_DAT_SNP_RESP_D  = 4'h1;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_PEND      = 2'd1,
        TX_SEND      = 2'd2,
        TX_SEND_PEND = 2'd3
    } tx_state_e;

    function automatic logic tx_state_has_pend(input tx_state_e st);
        return (st == TX_PEND) || (st == TX_SEND_PEND);
    endfunction

    function automatic logic tx_state_has_send(input tx_state_e st);
        return (st == TX_SEND) || (st == TX_SEND_PEND);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chi_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; scans upward from ptr and
//               grants the first requester (one-hot), wrapping at NUM_SRC.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant
);

    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUM_SRC);

    logic [PTR_W:0] slot;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            slot = {1'b0, ptr} + (PTR_W+1)'(k);
            if (slot >= N_EXT) begin
                slot = slot - N_EXT;
            end
            if (!found && req[slot[PTR_W-1:0]]) begin
                grant[slot[PTR_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/chi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : chi_tx_scheduler
// Description : Round-robin, credit-gated scheduler of CHI flits onto one HN
//               TX channel, with FLITPEND issued one cycle ahead of FLITV.
// Revision    : 1.0 - initial release
// ============================================================================
module chi_tx_scheduler
    import chi_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int FLIT_W  = CHI_FLIT_W,
    parameter int MAX_CRD = REQ_MAX_CRD,
    parameter int CRD_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      link_en,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*FLIT_W-1:0] src_flit,
    output logic [NUM_SRC-1:0]        src_grant,
    output logic                      TX_FLITPEND,
    output logic                      TX_FLITV,
    output logic [FLIT_W-1:0]         TX_FLIT_128,
    input  logic                      TX_LCRDV,
    output logic [CRD_W-1:0]          crd_cnt,
    output logic                      crd_ovf
);

    localparam int               PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(MAX_CRD);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SRC - 1);

    tx_state_e          state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CRD_W-1:0]   crd_cnt_q, crd_cnt_d;
    logic               crd_ovf_q, crd_ovf_d;
    logic [FLIT_W-1:0]  pipe_flit_q, pipe_flit_d;
    logic [FLIT_W-1:0]  out_flit_q, out_flit_d;

    logic               can_grant;
    logic               grant_any;
    logic [NUM_SRC-1:0] arb_req;
    logic [NUM_SRC-1:0] arb_grant;
    logic [PTR_W-1:0]   win_idx;
    logic [FLIT_W-1:0]  win_flit;
    logic               pend_now;

    // A credit returned this very cycle is usable immediately.
    assign can_grant = link_en && ((crd_cnt_q != '0) || TX_LCRDV);
    assign arb_req   = can_grant ? src_valid : '0;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant)
    );

    assign grant_any = |arb_grant;

    always_comb begin
        win_idx  = '0;
        win_flit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (arb_grant[i]) begin
                win_idx  = PTR_W'(i);
                win_flit = src_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
        end
    end

    // Credits are debited at grant time so the slot is reserved for the flit.
    always_comb begin
        crd_cnt_d = crd_cnt_q;
        crd_ovf_d = crd_ovf_q;
        case ({TX_LCRDV, grant_any})
            2'b10: begin
                if (crd_cnt_q == CRD_MAX) begin
                    crd_ovf_d = 1'b1;
                end else begin
                    crd_cnt_d = crd_cnt_q + 1'b1;
                end
            end
            2'b01:   crd_cnt_d = crd_cnt_q - 1'b1;
            default: crd_cnt_d = crd_cnt_q;
        endcase
    end

    // State tracks which of the two pipe stages hold a flit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:      state_d = grant_any ? TX_PEND      : TX_IDLE;
            TX_PEND:      state_d = grant_any ? TX_SEND_PEND : TX_SEND;
            TX_SEND:      state_d = grant_any ? TX_PEND      : TX_IDLE;
            TX_SEND_PEND: state_d = grant_any ? TX_SEND_PEND : TX_SEND;
            default:      state_d = TX_IDLE;
        endcase
    end

    assign pend_now = tx_state_has_pend(state_q);

    always_comb begin
        pipe_flit_d = grant_any ? win_flit    : pipe_flit_q;
        out_flit_d  = pend_now  ? pipe_flit_q : out_flit_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            rr_ptr_q    <= '0;
            crd_cnt_q   <= '0;
            crd_ovf_q   <= 1'b0;
            pipe_flit_q <= '0;
            out_flit_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            crd_cnt_q   <= crd_cnt_d;
            crd_ovf_q   <= crd_ovf_d;
            pipe_flit_q <= pipe_flit_d;
            out_flit_q  <= out_flit_d;
        end
    end

    assign src_grant   = arb_grant;
    assign TX_FLITPEND = pend_now;
    assign TX_FLITV    = tx_state_has_send(state_q);
    assign TX_FLIT_128 = out_flit_q;
    assign crd_cnt     = crd_cnt_q;
    assign crd_ovf     = crd_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_chi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_chi_tx_scheduler
// Description : Vector-table bench for chi_tx_scheduler with a flit scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chi_tx_scheduler;

    localparam int NS = 4;
    localparam int FW = 128;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              link_en;
    logic [NS-1:0]     src_valid;
    logic [NS*FW-1:0]  src_flit;
    logic [NS-1:0]     src_grant;
    logic              TX_FLITPEND;
    logic              TX_FLITV;
    logic [FW-1:0]     TX_FLIT_128;
    logic              TX_LCRDV;
    logic [CW-1:0]     crd_cnt;
    logic              crd_ovf;

    chi_tx_scheduler #(
        .NUM_SRC (NS),
        .FLIT_W  (FW),
        .MAX_CRD (15),
        .CRD_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .link_en     (link_en),
        .src_valid   (src_valid),
        .src_flit    (src_flit),
        .src_grant   (src_grant),
        .TX_FLITPEND (TX_FLITPEND),
        .TX_FLITV    (TX_FLITV),
        .TX_FLIT_128 (TX_FLIT_128),
        .TX_LCRDV    (TX_LCRDV),
        .crd_cnt     (crd_cnt),
        .crd_ovf     (crd_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          link;
        logic [NS-1:0] valid;
        logic          lcrdv;
        logic [NS-1:0] grant;
        logic          pend;
        logic          flitv;
        logic [CW-1:0] crd;
        logic          ovf;
    } vec_t;

    vec_t          tbl[$];
    logic [FW-1:0] sb_q[$];
    logic [FW-1:0] last_flit;
    int            seq [NS];
    int            n_vec;
    int            n_err;

    function automatic logic [FW-1:0] flit_of(input int i);
        return {32'hC0DE_0000 + 32'(i), 64'h0123_4567_89AB_CDEF, 32'(seq[i])};
    endfunction

    function automatic vec_t mk(input logic link, input logic [NS-1:0] valid,
                                input logic lcrdv, input logic [NS-1:0] grant,
                                input logic pend, input logic flitv,
                                input logic [CW-1:0] crd, input logic ovf);
        vec_t v;
        v.link = link; v.valid = valid; v.lcrdv = lcrdv; v.grant = grant;
        v.pend = pend; v.flitv = flitv; v.crd = crd; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_flits();
        for (int i = 0; i < NS; i++) src_flit[i*FW +: FW] = flit_of(i);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic apply(input vec_t v);
        link_en   = v.link;
        src_valid = v.valid;
        TX_LCRDV  = v.lcrdv;
        drive_flits();
        @(negedge clk);
        n_vec++;
        chk("src_grant", src_grant, v.grant);
        chk("flitpend", TX_FLITPEND, v.pend);
        chk("flitv", TX_FLITV, v.flitv);
        chk("crd_cnt", crd_cnt, v.crd);
        chk("crd_ovf", crd_ovf, v.ovf);
        if (v.flitv) begin
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty: flit due but nothing was granted");
            end else begin
                last_flit = sb_q.pop_front();
            end
        end
        chk("tx_flit", TX_FLIT_128, last_flit);
        for (int i = 0; i < NS; i++) begin
            if (v.grant[i]) begin
                sb_q.push_back(flit_of(i));
                seq[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        chk(name, FW'(sb_q.size()), '0);
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        link_en   = 1'b0;
        src_valid = '0;
        TX_LCRDV  = 1'b0;
        @(negedge clk);
        n_vec++;
        chk("rst_grant", src_grant, '0);
        chk("rst_flitpend", TX_FLITPEND, '0);
        chk("rst_flitv", TX_FLITV, '0);
        chk("rst_flit", TX_FLIT_128, '0);
        chk("rst_crd_cnt", crd_cnt, '0);
        chk("rst_crd_ovf", crd_ovf, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        last_flit = '0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        last_flit = '0;
        for (int i = 0; i < NS; i++) seq[i] = 0;
        rst       = 1'b1;
        link_en   = 1'b0;
        src_valid = '0;
        TX_LCRDV  = 1'b0;
        drive_flits();
        @(posedge clk);
        #1;

        // Three credits, single requester: three grants, fourth stalls.
        do_reset();
        tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd2, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd3, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 4'd2, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 4'd1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));
        run_table();
        check_drained("t1_drained");

        // All sources valid with 8 credits: order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'(i), 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd8, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 4'd7, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b1, 4'd6, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 4'd5, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b1, 4'd4, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b1, 4'd3, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b1, 4'd2, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 4'd1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));
        run_table();
        check_drained("t2_drained");

        // Same-cycle credit with zero held, then pointer wrap 3 -> 0.
        do_reset();
        tbl.push_back(mk(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b0, 1'b0, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));
        run_table();
        check_drained("t3_drained");

        // Sixteen credits with no traffic: saturate at 15, sticky overflow.
        do_reset();
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'(i), 1'b0));
        tbl.push_back(mk(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd15, 1'b1));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd14, 1'b1));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd14, 1'b1));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd14, 1'b1));
        run_table();
        check_drained("t4_drained");

        // link_en drops after two back-to-back grants.
        do_reset();
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'(i), 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd4, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 4'd3, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd2, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd2, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd2, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0100, 1'b0, 1'b0, 4'd2, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd1, 1'b0));
        run_table();
        check_drained("t5_drained");

        // Asynchronous reset while both pipe stages are occupied.
        do_reset();
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'(i), 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd3, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 4'd2, 1'b0));
        run_table();
        link_en   = 1'b1;
        src_valid = '0;
        TX_LCRDV  = 1'b0;
        @(negedge clk);
        n_vec++;
        chk("sp_flitpend", TX_FLITPEND, 1'b1);
        chk("sp_flitv", TX_FLITV, 1'b1);
        chk("sp_crd_cnt", crd_cnt, 4'd1);
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sp_sb_empty: no flit queued for SEND_PEND cycle");
        end else begin
            last_flit = sb_q.pop_front();
        end
        chk("sp_flit", TX_FLIT_128, last_flit);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        chk("arst_flitpend", TX_FLITPEND, '0);
        chk("arst_flitv", TX_FLITV, '0);
        chk("arst_flit", TX_FLIT_128, '0);
        chk("arst_crd_cnt", crd_cnt, '0);
        chk("arst_grant", src_grant, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        last_flit = '0;
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));
        run_table();
        check_drained("t6_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
